// File: rtl/snn_out_spike_collector.sv
// Output-spike collector: stores result packets per (layer, timestep) bank and drains each
// completed map in address order as start/header/stream/done valid-ready transactions.
module snn_out_spike_collector #(
  parameter int         WIDTH_PACKAGE = 50,
  parameter int         OPCODE_START  = 37,
  parameter int         OPCODE_END    = 32,
  parameter int         DATA_START    = 31,
  parameter int         DATA_END      = 0,
  parameter logic [5:0] OP_SPIKE      = 6'h05,
  parameter int         DEPTH_R       = 21,
  parameter int         NUM_TS        = 2,
  parameter int         NUM_LAYERS    = 1,
  parameter int         OUT_W         = 13,
  parameter int         ADDR_W        = 12,
  parameter int         TS_W          = 2,
  parameter int         LAYER_W       = 2
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [WIDTH_PACKAGE-1:0] in_pkt,
  output logic                     start_valid,
  input  logic                     start_ready,
  output logic                     hdr_valid,
  input  logic                     hdr_ready,
  output logic [TS_W-1:0]          hdr_ts,
  output logic [LAYER_W-1:0]       hdr_layer,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [ADDR_W-1:0]        out_addr,
  output logic [OUT_W-1:0]         out_data,
  output logic                     done_valid,
  input  logic                     done_ready,
  output logic                     err_pulse
);

  localparam int MAP    = DEPTH_R * DEPTH_R;
  localparam int TOT    = NUM_TS * MAP;
  localparam int IDX_W  = (TOT > 1) ? $clog2(TOT) : 1;
  localparam int TSI_W  = (NUM_TS > 1) ? $clog2(NUM_TS) : 1;
  localparam int OP_W   = OPCODE_START - OPCODE_END + 1;
  localparam int DATA_W = DATA_START - DATA_END + 1;
  localparam int FLD_W  = OUT_W + ADDR_W + TS_W + LAYER_W;

  localparam logic [ADDR_W:0]        MAP_F      = (ADDR_W+1)'(MAP);
  localparam logic [ADDR_W:0]        MAP_F_M1   = (ADDR_W+1)'(MAP - 1);
  localparam logic [ADDR_W-1:0]      MAP_A      = ADDR_W'(MAP);
  localparam logic [ADDR_W-1:0]      LAST_A     = ADDR_W'(MAP - 1);
  localparam logic [TS_W-1:0]        TS_LAST    = TS_W'(NUM_TS - 1);
  localparam logic [LAYER_W-1:0]     LAYER_LAST = LAYER_W'(NUM_LAYERS - 1);
  localparam logic [TOT-1:0]         BANK0      = TOT'({MAP{1'b1}});

  typedef enum logic [2:0] {S_IDLE, S_FILL, S_START, S_HDR, S_STREAM, S_DONE} state_t;

  state_t                   r_state;
  logic [TS_W-1:0]          r_cur_ts;
  logic [LAYER_W-1:0]       r_cur_layer;
  logic                     r_first;
  logic                     r_start_valid;
  logic                     r_hdr_valid;
  logic [TS_W-1:0]          r_hdr_ts;
  logic [LAYER_W-1:0]       r_hdr_layer;
  logic                     r_out_valid;
  logic [ADDR_W-1:0]        r_out_addr;
  logic [OUT_W-1:0]         r_out_data;
  logic                     r_done_valid;
  logic                     r_err;
  logic [TOT-1:0]           r_wr;
  logic [NUM_TS-1:0][ADDR_W:0] r_fill;
  logic [OUT_W-1:0]         r_mem [TOT];

  logic [OP_W-1:0]          w_op;
  logic [DATA_W-1:0]        w_data;
  logic [OUT_W-1:0]         w_val;
  logic [ADDR_W-1:0]        w_addr;
  logic [TS_W-1:0]          w_ts;
  logic [LAYER_W-1:0]       w_layer;
  logic [TSI_W-1:0]         w_ts_i;
  logic [TSI_W-1:0]         w_cur_i;
  logic [IDX_W-1:0]         w_wr_idx;
  logic [ADDR_W-1:0]        w_rd_addr;
  logic [IDX_W-1:0]         w_rd_idx;
  logic [TOT-1:0]           w_clr_mask;
  logic                     w_xfer;
  logic                     w_bad;
  logic                     w_dup;
  logic                     w_wr;
  logic                     w_full;
  logic                     w_last;
  logic                     w_clr;
  logic                     w_unused_bits;

  assign w_op    = in_pkt[OPCODE_START:OPCODE_END];
  assign w_data  = in_pkt[DATA_START:DATA_END];
  assign w_val   = w_data[OUT_W-1:0];
  assign w_addr  = w_data[OUT_W +: ADDR_W];
  assign w_ts    = w_data[OUT_W+ADDR_W +: TS_W];
  assign w_layer = w_data[OUT_W+ADDR_W+TS_W +: LAYER_W];
  assign w_unused_bits = ^{in_pkt[WIDTH_PACKAGE-1:OPCODE_START+1], w_data[DATA_W-1:FLD_W]};

  assign w_ts_i   = TSI_W'(w_ts);
  assign w_cur_i  = TSI_W'(r_cur_ts);
  assign w_wr_idx = IDX_W'(w_ts_i) * IDX_W'(MAP) + IDX_W'(w_addr);

  // Packets for a later layer stall at the port until the current layer has fully drained
  assign in_ready = !reset && (r_state != S_DONE) && (w_layer == r_cur_layer);
  assign w_xfer   = in_valid && in_ready;
  assign w_bad    = (w_op != OP_W'(OP_SPIKE)) || (w_addr >= MAP_A) ||
                    ({1'b0, w_ts} >= (TS_W+1)'(NUM_TS));
  assign w_dup    = !w_bad && r_wr[w_wr_idx];
  assign w_wr     = w_xfer && !w_bad && !w_dup;

  // Look ahead one write so the FSM reacts in the cycle right after the completing packet
  assign w_full = (r_fill[w_cur_i] == MAP_F) ||
                  (w_wr && (w_ts_i == w_cur_i) && (r_fill[w_cur_i] == MAP_F_M1));

  assign w_last     = (r_out_addr == LAST_A);
  assign w_clr      = (r_state == S_STREAM) && r_out_valid && out_ready && w_last;
  assign w_clr_mask = BANK0 << (IDX_W'(w_cur_i) * IDX_W'(MAP));
  assign w_rd_addr  = (r_state == S_STREAM) ? r_out_addr + ADDR_W'(1) : '0;
  assign w_rd_idx   = IDX_W'(w_cur_i) * IDX_W'(MAP) + IDX_W'(w_rd_addr);

  always_ff @(posedge clk) begin
    if (w_wr) r_mem[w_wr_idx] <= w_val;
  end

  // A drained bank and the bank being written are always distinct, so clear and set never collide
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wr   <= '0;
      r_fill <= '0;
      r_err  <= 1'b0;
    end else begin
      r_err <= w_xfer && (w_bad || w_dup);
      if (w_clr) begin
        r_wr             <= r_wr & ~w_clr_mask;
        r_fill[w_cur_i]  <= '0;
      end
      if (w_wr) begin
        r_wr[w_wr_idx]   <= 1'b1;
        r_fill[w_ts_i]   <= r_fill[w_ts_i] + (ADDR_W+1)'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state       <= S_IDLE;
      r_cur_ts      <= '0;
      r_cur_layer   <= '0;
      r_first       <= 1'b1;
      r_start_valid <= 1'b0;
      r_hdr_valid   <= 1'b0;
      r_hdr_ts      <= '0;
      r_hdr_layer   <= '0;
      r_out_valid   <= 1'b0;
      r_out_addr    <= '0;
      r_out_data    <= '0;
      r_done_valid  <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: r_state <= S_FILL;
        S_FILL: begin
          if (w_full) begin
            if (r_first) begin
              r_first       <= 1'b0;
              r_start_valid <= 1'b1;
              r_state       <= S_START;
            end else begin
              r_hdr_valid <= 1'b1;
              r_hdr_ts    <= r_cur_ts + TS_W'(1);
              r_hdr_layer <= r_cur_layer + LAYER_W'(1);
              r_state     <= S_HDR;
            end
          end
        end
        S_START: begin
          if (start_ready) begin
            r_start_valid <= 1'b0;
            r_hdr_valid   <= 1'b1;
            r_hdr_ts      <= r_cur_ts + TS_W'(1);
            r_hdr_layer   <= r_cur_layer + LAYER_W'(1);
            r_state       <= S_HDR;
          end
        end
        S_HDR: begin
          if (hdr_ready) begin
            r_hdr_valid <= 1'b0;
            r_out_valid <= 1'b1;
            r_out_addr  <= '0;
            r_out_data  <= r_mem[w_rd_idx];
            r_state     <= S_STREAM;
          end
        end
        S_STREAM: begin
          if (out_ready) begin
            if (w_last) begin
              r_out_valid <= 1'b0;
              if (r_cur_ts == TS_LAST) begin
                r_cur_ts <= '0;
                if (r_cur_layer == LAYER_LAST) begin
                  r_done_valid <= 1'b1;
                  r_state      <= S_DONE;
                end else begin
                  r_cur_layer <= r_cur_layer + LAYER_W'(1);
                  r_state     <= S_FILL;
                end
              end else begin
                r_cur_ts <= r_cur_ts + TS_W'(1);
                r_state  <= S_FILL;
              end
            end else begin
              r_out_addr <= w_rd_addr;
              r_out_data <= r_mem[w_rd_idx];
            end
          end
        end
        S_DONE: begin
          if (done_ready) r_done_valid <= 1'b0;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign start_valid = r_start_valid;
  assign hdr_valid   = r_hdr_valid;
  assign hdr_ts      = r_hdr_ts;
  assign hdr_layer   = r_hdr_layer;
  assign out_valid   = r_out_valid;
  assign out_addr    = r_out_addr;
  assign out_data    = r_out_data;
  assign done_valid  = r_done_valid;
  assign err_pulse   = r_err;

endmodule

// File: tb/tb_snn_out_spike_collector.sv
// Randomised bench for the spike collector: packet lists per layer are scored against an
// array-based model of first-written values, error counts and the expected drain sequence.
module tb_snn_out_spike_collector;

  localparam int DEPTH_R = 3;
  localparam int MAP     = DEPTH_R * DEPTH_R;
  localparam int NUM_TS  = 2;
  localparam int NUM_LAY = 2;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [49:0] in_pkt;
  logic        start_valid, start_ready;
  logic        hdr_valid, hdr_ready;
  logic [1:0]  hdr_ts, hdr_layer;
  logic        out_valid, out_ready;
  logic [11:0] out_addr;
  logic [12:0] out_data;
  logic        done_valid, done_ready;
  logic        err_pulse;

  snn_out_spike_collector #(.DEPTH_R(DEPTH_R), .NUM_TS(NUM_TS), .NUM_LAYERS(NUM_LAY)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_pkt(in_pkt),
    .start_valid(start_valid), .start_ready(start_ready),
    .hdr_valid(hdr_valid), .hdr_ready(hdr_ready), .hdr_ts(hdr_ts), .hdr_layer(hdr_layer),
    .out_valid(out_valid), .out_ready(out_ready), .out_addr(out_addr), .out_data(out_data),
    .done_valid(done_valid), .done_ready(done_ready),
    .err_pulse(err_pulse)
  );

  always #5 clk = ~clk;

  typedef struct {int op; int layer; int ts; int addr; int val;} pkt_t;

  pkt_t pq[$];
  int   expq[$];
  int   obsq[$];
  int   exp_err, obs_err;
  int   checks = 0;
  int   failures = 0;
  bit   abort;

  task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic int ev(int k, int x, int y);
    return (k << 28) | (x << 16) | y;
  endfunction

  function automatic logic [49:0] mk_pkt(pkt_t p);
    logic [49:0] w;
    w = '0;
    w[37:32] = p.op[5:0];
    w[28:27] = p.layer[1:0];
    w[26:25] = p.ts[1:0];
    w[24:13] = p.addr[11:0];
    w[12:0]  = p.val[12:0];
    return w;
  endfunction

  // modes: 0 ordered, 1 ts0 reversed, 2 ts1 first, 3 shuffled+errors, 4 directed duplicate, 5 ordered+errors
  task automatic gen_layer(input int l, input int mode);
    int tsl[$], adl[$];
    int cnt[2];
    int j, tmp, k, v;
    pkt_t p;
    for (int t = 0; t < NUM_TS; t++)
      for (int a = 0; a < MAP; a++) begin
        int tt, aa;
        tt = (mode == 2) ? 1 - t : t;
        aa = (mode == 1 && tt == 0) ? MAP - 1 - a : a;
        tsl.push_back(tt);
        adl.push_back(aa);
      end
    if (mode == 3)
      for (int i = tsl.size() - 1; i > 0; i--) begin
        j = $urandom_range(0, i);
        tmp = tsl[i]; tsl[i] = tsl[j]; tsl[j] = tmp;
        tmp = adl[i]; adl[i] = adl[j]; adl[j] = tmp;
      end
    cnt[0] = 0; cnt[1] = 0;
    for (int i = 0; i < tsl.size(); i++) begin
      v = (mode == 3 || mode == 5) ? $urandom_range(0, 8191) : adl[i] + 1;
      if (mode == 4 && tsl[i] == 0 && adl[i] == 4) v = 7;
      p = '{5, l, tsl[i], adl[i], v};
      pq.push_back(p);
      cnt[tsl[i]]++;
      if (mode == 4 && tsl[i] == 0 && adl[i] == 4) begin
        pq.push_back('{5, l, 0, 4, 3});
        pq.push_back('{63, l, 0, 1, 1});
        pq.push_back('{5, l, 0, 9, 1});
      end
      if ((mode == 3 || mode == 5) && i < tsl.size() - 1 && $urandom_range(0, 3) == 0) begin
        k = $urandom_range(0, 3);
        if (k == 3 && cnt[tsl[i]] >= MAP) k = 2;
        case (k)
          0: p = '{(5 + $urandom_range(1, 62)) % 64, l, tsl[i], adl[i], 1};
          1: p = '{5, l, tsl[i], $urandom_range(MAP, 4095), 2};
          2: p = '{5, l, $urandom_range(NUM_TS, 3), adl[i], 3};
          default: p = '{5, l, tsl[i], adl[i], $urandom_range(0, 8191)};
        endcase
        pq.push_back(p);
      end
    end
  endtask

  task automatic build_expect();
    int  val  [NUM_LAY][NUM_TS][MAP];
    bit  seen [NUM_LAY][NUM_TS][MAP];
    foreach (seen[a, b, c]) seen[a][b][c] = 1'b0;
    exp_err = 0;
    expq.delete();
    foreach (pq[i]) begin
      if (pq[i].op != 5 || pq[i].addr >= MAP || pq[i].ts >= NUM_TS) exp_err++;
      else if (seen[pq[i].layer][pq[i].ts][pq[i].addr]) exp_err++;
      else begin
        seen[pq[i].layer][pq[i].ts][pq[i].addr] = 1'b1;
        val[pq[i].layer][pq[i].ts][pq[i].addr]  = pq[i].val;
      end
    end
    expq.push_back(ev(1, 0, 0));
    for (int l = 0; l < NUM_LAY; l++)
      for (int t = 0; t < NUM_TS; t++) begin
        expq.push_back(ev(2, t + 1, l + 1));
        for (int a = 0; a < MAP; a++) expq.push_back(ev(3, a, val[l][t][a]));
      end
    expq.push_back(ev(4, 0, 0));
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1; in_valid = 1'b0; in_pkt = '0;
    start_ready = 1'b0; hdr_ready = 1'b0; out_ready = 1'b0; done_ready = 1'b0;
    @(negedge clk);
    #1;
    chk_eq("rst_ctl", {in_ready, start_valid, hdr_valid, out_valid, done_valid, err_pulse}, 0);
    chk_eq("rst_dat", {hdr_ts, hdr_layer, out_addr, out_data}, 0);
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic feed(input int idle_at);
    int last_layer, n;
    last_layer = 0;
    for (int i = 0; i < pq.size(); i++) begin
      if (abort) break;
      @(negedge clk);
      in_valid = 1'b0;
      if (i == idle_at) begin
        repeat (4) @(negedge clk);
        #1 chk_eq("no_early_out", {start_valid, hdr_valid, out_valid}, 0);
      end
      if ($urandom_range(0, 3) == 0) @(negedge clk);
      in_pkt = mk_pkt(pq[i]);
      in_valid = 1'b1;
      #1;
      if (pq[i].layer != last_layer) begin
        chk_eq("layer_stall", in_ready, 0);
        last_layer = pq[i].layer;
      end
      n = 0;
      while (!in_ready && n < 3000 && !abort) begin
        @(negedge clk);
        #1;
        n++;
      end
      if (abort) break;
      if (!in_ready) begin
        chk_eq("in_ready_timeout", in_ready, 1);
        abort = 1'b1;
      end
    end
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic monitor(input int rmode);
    int n;
    bit got_done, prev_stall, hdr_taken;
    logic [11:0] p_addr;
    logic [12:0] p_data;
    n = 0; got_done = 0; prev_stall = 0; hdr_taken = 0;
    obs_err = 0;
    obsq.delete();
    while (!got_done && n < 6000) begin
      @(negedge clk);
      case (rmode)
        0: begin start_ready = 1; hdr_ready = 1; out_ready = 1; done_ready = 1; end
        1: begin start_ready = 1; hdr_ready = 1; out_ready = ~out_ready; done_ready = 1; end
        default: begin
          start_ready = $urandom_range(0, 1); hdr_ready  = $urandom_range(0, 1);
          out_ready   = $urandom_range(0, 1); done_ready = $urandom_range(0, 1);
        end
      endcase
      #1;
      if (hdr_taken) chk_eq("out_after_hdr", out_valid, 1);
      hdr_taken = 0;
      if (prev_stall) begin
        chk_eq("stall_valid", out_valid, 1);
        chk_eq("stall_addr", out_addr, p_addr);
        chk_eq("stall_data", out_data, p_data);
      end
      prev_stall = out_valid && !out_ready;
      p_addr = out_addr;
      p_data = out_data;
      if (err_pulse) obs_err++;
      if (start_valid && start_ready) obsq.push_back(ev(1, 0, 0));
      if (hdr_valid && hdr_ready) begin
        obsq.push_back(ev(2, hdr_ts, hdr_layer));
        hdr_taken = 1;
      end
      if (out_valid && out_ready) obsq.push_back(ev(3, out_addr, out_data));
      if (done_valid && done_ready) begin
        obsq.push_back(ev(4, 0, 0));
        got_done = 1;
      end
      n++;
    end
    chk_eq("done_seen", got_done, 1);
    if (got_done) begin
      @(negedge clk);
      #1 chk_eq("done_quiet", {done_valid, in_ready, out_valid, hdr_valid}, 0);
    end
    abort = 1'b1;
  endtask

  task automatic compare();
    int m;
    chk_eq("ev_count", obsq.size(), expq.size());
    m = (obsq.size() < expq.size()) ? obsq.size() : expq.size();
    for (int i = 0; i < m; i++) chk_eq($sformatf("ev%0d", i), obsq[i], expq[i]);
    chk_eq("err_count", obs_err, exp_err);
  endtask

  task automatic run(input int m0, input int m1, input int rmode, input int idle_at, input bit rst);
    pq.delete();
    gen_layer(0, m0);
    gen_layer(1, m1);
    build_expect();
    if (rst) do_reset();
    abort = 1'b0;
    fork
      feed(idle_at);
      monitor(rmode);
    join
    compare();
  endtask

  task automatic reset_in_stream();
    int n;
    pq.delete();
    gen_layer(0, 0);
    gen_layer(1, 0);
    do_reset();
    abort = 1'b0;
    start_ready = 1; hdr_ready = 1; out_ready = 1; done_ready = 1;
    fork
      feed(-1);
      begin
        n = 0;
        while (!out_valid && n < 2000) begin
          @(posedge clk);
          n++;
        end
        #1 chk_eq("reach_stream", out_valid, 1);
        @(posedge clk);
        #2 reset = 1'b1;
        abort = 1'b1;
        #1;
        chk_eq("rst_stream_ctl", {in_ready, start_valid, hdr_valid, out_valid, done_valid, err_pulse}, 0);
        chk_eq("rst_stream_dat", {hdr_ts, hdr_layer, out_addr, out_data}, 0);
      end
    join
    @(negedge clk);
    reset = 1'b0;
    repeat (30) @(negedge clk);
    #1 chk_eq("no_resume", {start_valid, hdr_valid, out_valid, done_valid}, 0);
  endtask

  initial begin
    reset = 1'b1; in_valid = 1'b0; in_pkt = '0;
    start_ready = 0; hdr_ready = 0; out_ready = 0; done_ready = 0;
    run(0, 0, 0, -1, 1);
    run(1, 0, 0, -1, 1);
    run(2, 0, 0, 9, 1);
    run(4, 0, 2, -1, 1);
    run(0, 0, 1, -1, 1);
    reset_in_stream();
    run(3, 5, 2, -1, 0);
    for (int r = 0; r < 4; r++) run(3, 3, r % 3, -1, 1);
    run(5, 4, 1, -1, 1);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

endmodule
